// File: rtl/slice_cfg_pkg.sv
// Shared types and sizing helpers for the slice configuration controller.
// ERROR state only exists when SLICE_CFG_PARITY_EN is defined.
package slice_cfg_pkg;

  localparam int LUTS_PER_SLICE = 2;

`ifdef SLICE_CFG_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } slice_cfg_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_RUN   = 3'd4
  } slice_cfg_state_t;
`endif

  // Width of a counter that indexes every LUT word on the chain.
  function automatic int wordCntW(input int numSlices);
    int n;
    n = LUTS_PER_SLICE * numSlices;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Parallel-load, LSB-first shift register feeding the slice config chain.
// A marker bit above the data flags the final bit without a counter.
module cfg_serializer #(
  parameter int W = 8
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         sdo,
  output logic         lastBit
);

  logic [W:0] sr;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)    sr <= '0;
    else if (load)  sr <= {1'b1, data};
    else if (shift) sr <= {1'b0, sr[W:1]};
  end

  assign sdo     = sr[0];
  // Marker has walked down to bit 1 exactly when bit 0 is the final data bit.
  assign lastBit = (sr[W:1] == W'(1));

endmodule

// File: rtl/slice_cfg_ctrl.sv
// Loads LUT truth tables onto the slice config chain, then enables the array.
// Define SLICE_CFG_PARITY_EN to add the cfg_par input and the ERROR state.
module slice_cfg_ctrl
  import slice_cfg_pkg::*;
#(
  parameter int NUM_SLICES = 4,
  parameter int LUT_BITS   = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic                abort,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [LUT_BITS-1:0] cfg_data,
`ifdef SLICE_CFG_PARITY_EN
  input  logic                cfg_par,
`endif
  output logic                cfg_sdo,
  output logic                cfg_shift_en,
  output logic                cfg_done,
  output logic                slice_en,
  output logic                cfg_err
);

  localparam int WCW = wordCntW(NUM_SLICES);
  localparam int BCW = (LUT_BITS > 1) ? $clog2(LUT_BITS) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(LUTS_PER_SLICE * NUM_SLICES - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(LUT_BITS - 1);

  slice_cfg_state_t state, nextState;
  logic [WCW-1:0] wordCnt;
  logic [BCW-1:0] bitCnt;
  logic capture, shiftStep, cntInc, cntClr;
  logic serSdo, serLast, wordEnd;

  cfg_serializer #(.W(LUT_BITS)) uSer (
    .gclk   (CLK),
    .grst_n (RST_N),
    .load   (capture),
    .shift  (shiftStep),
    .data   (cfg_data),
    .sdo    (serSdo),
    .lastBit(serLast)
  );

  assign wordEnd = serLast && (bitCnt == BIT_LAST);

`ifdef SLICE_CFG_PARITY_EN
  logic parBad;
  assign parBad = ^{cfg_data, cfg_par};
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      wordCnt <= '0;
      bitCnt  <= '0;
    end else begin
      state <= nextState;
      if (cntClr)      wordCnt <= '0;
      else if (cntInc) wordCnt <= wordCnt + 1'b1;
      if (cntClr || capture) bitCnt <= '0;
      else if (shiftStep)    bitCnt <= bitCnt + 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    capture   = 1'b0;
    shiftStep = 1'b0;
    cntInc    = 1'b0;
    cntClr    = 1'b0;
    unique case (state)
      S_IDLE: if (start) begin
        nextState = S_LOAD;
        cntClr    = 1'b1;
      end
      S_LOAD: begin
`ifdef SLICE_CFG_PARITY_EN
        // A bad word is dropped before it can reach the chain.
        if (cfg_valid && parBad) nextState = S_ERROR;
        else
`endif
        if (cfg_valid) begin
          capture   = 1'b1;
          nextState = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shiftStep = 1'b1;
        if (wordEnd) begin
          if (wordCnt < WORD_LAST) begin
            cntInc    = 1'b1;
            nextState = S_LOAD;
          end else begin
            nextState = S_DONE;
          end
        end
      end
      S_DONE: nextState = S_RUN;
      S_RUN: if (start) begin
        nextState = S_LOAD;
        cntClr    = 1'b1;
      end
`ifdef SLICE_CFG_PARITY_EN
      S_ERROR: if (start) begin
        nextState = S_LOAD;
        cntClr    = 1'b1;
      end
`endif
      default: nextState = S_IDLE;
    endcase
    // Abort overrides everything, including a coincident start.
    if (abort) begin
      nextState = S_IDLE;
      capture   = 1'b0;
      shiftStep = 1'b0;
      cntInc    = 1'b0;
      cntClr    = 1'b1;
    end
  end

  assign cfg_ready    = (state == S_LOAD);
  assign cfg_shift_en = (state == S_SHIFT);
  assign cfg_sdo      = cfg_shift_en & serSdo;
  assign cfg_done     = (state == S_DONE);
  assign slice_en     = (state == S_RUN);
`ifdef SLICE_CFG_PARITY_EN
  assign cfg_err      = (state == S_ERROR);
`else
  assign cfg_err      = 1'b0;
`endif

endmodule

// File: tb/tb_slice_cfg_ctrl.sv
// Directed bench for slice_cfg_ctrl: full load, stall, abort, reload, reset, parity.
module tb_slice_cfg_ctrl;

  logic CLK = 1'b0;
  logic RST_N, start, abort, cfg_valid;
  logic [7:0] cfg_data;
`ifdef SLICE_CFG_PARITY_EN
  logic cfg_par;
`endif
  logic cfg_ready, cfg_sdo, cfg_shift_en, cfg_done, slice_en, cfg_err;

  int checks = 0;
  int errors = 0;
  logic sdoQ[$];
  int doneCnt = 0;
  logic [7:0] expW [8];

  always #5 CLK = ~CLK;

  slice_cfg_ctrl #(.NUM_SLICES(4), .LUT_BITS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
`ifdef SLICE_CFG_PARITY_EN
    .cfg_par(cfg_par),
`endif
    .cfg_sdo(cfg_sdo), .cfg_shift_en(cfg_shift_en), .cfg_done(cfg_done),
    .slice_en(slice_en), .cfg_err(cfg_err)
  );

  always @(negedge CLK) begin
    if (cfg_shift_en) sdoQ.push_back(cfg_sdo);
    if (cfg_done) doneCnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_ready"}, cfg_ready, 0);
    chk({tag, "_shift"}, cfg_shift_en, 0);
    chk({tag, "_sdo"}, cfg_sdo, 0);
    chk({tag, "_done"}, cfg_done, 0);
    chk({tag, "_sen"}, slice_en, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  task automatic sendWord(input logic [7:0] w, output int waited);
    cfg_data = w;
`ifdef SLICE_CFG_PARITY_EN
    cfg_par = ^w;
`endif
    cfg_valid = 1'b1;
    waited = 0;
    while (!cfg_ready && waited < 40) begin
      step();
      waited++;
    end
    if (!cfg_ready) chk("ready_timeout", cfg_ready, 1);
    step();
  endtask

  // Sends expW[0..7] with valid held high; optional 5-cycle host stall
  // before word stallAt and an ignored start pulse during the first shift.
  task automatic loadAll(input string tag, input int stallAt, input bit pokeStart);
    int waited, n, expWait;
    bit ok;
    logic [7:0] got;
    sdoQ.delete();
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == stallAt) begin
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_ready && n < 40) begin step(); n++; end
        ok = 1'b1;
        repeat (5) begin
          step();
          if (!(cfg_ready === 1'b1 && cfg_shift_en === 1'b0)) ok = 1'b0;
        end
        chk({tag, "_stall_hold"}, ok, 1);
      end
      sendWord(expW[i], waited);
      if (i == 0) begin
        chk({tag, "_first_shift"}, cfg_shift_en, 1);
        chk({tag, "_first_notready"}, cfg_ready, 0);
        if (pokeStart) begin
          start = 1'b1;
          step();
          start = 1'b0;
        end
      end else if (i != stallAt) begin
        expWait = (pokeStart && i == 1) ? 7 : 8;
        chk($sformatf("%s_wait%0d", tag, i), waited, expWait);
      end
    end
    chk({tag, "_last_shift"}, cfg_shift_en, 1);
    repeat (8) step();
    chk({tag, "_done_pulse"}, cfg_done, 1);
    chk({tag, "_sen_early"}, slice_en, 0);
    step();
    chk({tag, "_done_fall"}, cfg_done, 0);
    chk({tag, "_sen"}, slice_en, 1);
    cfg_valid = 1'b0;
    chk({tag, "_nbits"}, sdoQ.size(), 64);
    chk({tag, "_ndone"}, doneCnt, 1);
    for (int k = 0; k < 8; k++) begin
      got = '0;
      for (int b = 0; b < 8; b++)
        if (k * 8 + b < sdoQ.size()) got[b] = sdoQ[k * 8 + b];
      chk($sformatf("%s_word%0d", tag, k), got, expW[k]);
    end
  endtask

  initial begin
    int waited;
    logic [3:0] nib;
    RST_N = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
`ifdef SLICE_CFG_PARITY_EN
    cfg_par = 1'b0;
`endif
    repeat (2) step();
    chkAllZero("reset");

    // valid while idle must not be consumed
    cfg_valid = 1'b1; cfg_data = 8'h55;
    RST_N = 1'b1;
    repeat (2) step();
    chk("idle_valid_ready", cfg_ready, 0);
    chk("idle_valid_shift", cfg_shift_en, 0);
    cfg_valid = 1'b0;

    // full load, back to back
    start = 1'b1; step(); start = 1'b0;
    chk("start_ready", cfg_ready, 1);
    for (int i = 0; i < 8; i++) expW[i] = 8'(i + 1);
    loadAll("full", -1, 1'b0);

    // reload from RUN with stall and an ignored start during shift
    start = 1'b1; step(); start = 1'b0;
    chk("reload_sen", slice_en, 0);
    chk("reload_ready", cfg_ready, 1);
    expW = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h96, 8'h5A};
    loadAll("stall", 3, 1'b1);

    // abort in shift cycle 3 of word 2
    start = 1'b1; step(); start = 1'b0;
    sdoQ.delete();
    sendWord(8'h11, waited);
    sendWord(8'h22, waited);
    repeat (3) step();
    abort = 1'b1; step(); abort = 1'b0;
    cfg_valid = 1'b0;
    chk("abort_ready", cfg_ready, 0);
    chk("abort_shift", cfg_shift_en, 0);
    chk("abort_sen", slice_en, 0);
    chk("abort_nbits", sdoQ.size(), 12);
    nib = '0;
    for (int b = 0; b < 4; b++) if (8 + b < sdoQ.size()) nib[b] = sdoQ[8 + b];
    chk("abort_partial", nib, 4'h2);

    // abort beats simultaneous start
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("abort_wins", cfg_ready, 0);

    start = 1'b1; step(); start = 1'b0;
    chk("restart_ready", cfg_ready, 1);
    expW = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'hC3};
    loadAll("after_abort", -1, 1'b0);

    // async reset mid-LOAD
    start = 1'b1; step(); start = 1'b0;
    chk("prereset_ready", cfg_ready, 1);
    #2 RST_N = 1'b0;
    #1 chkAllZero("async_rst");
    start = 1'b1; step();
    chk("rst_start_ignored", cfg_ready, 0);
    start = 1'b0; RST_N = 1'b1;
    step();
    chk("post_rst_idle", cfg_ready, 0);

`ifdef SLICE_CFG_PARITY_EN
    start = 1'b1; step(); start = 1'b0;
    sdoQ.delete();
    cfg_data = 8'h03; cfg_par = 1'b1; cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0;
    chk("par_err", cfg_err, 1);
    chk("par_noshift", cfg_shift_en, 0);
    step();
    chk("par_hold", cfg_err, 1);
    chk("par_nbits", sdoQ.size(), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("par_clear", cfg_err, 0);
    chk("par_ready", cfg_ready, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_cfg_ctrl.md
# slice_cfg_ctrl

Configuration controller for an array of `NUM_SLICES` logic slices. Each slice contains two 3-input LUTs and an output register. The controller accepts LUT truth-table bytes from a host over a valid/ready interface. It serializes them onto a shared configuration shift chain, LSB first. Once every LUT is loaded it enables the array. It sits between the host/config bus and the slice array, and it is the only block that drives the slice chain's shift and enable controls.

## Interface
Parameters:
- `NUM_SLICES`, default 4: number of slices on the chain. Each slice has 2 LUTs.
- `LUT_BITS`, default 8: truth-table bits per LUT, equal to the config word width.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin or restart a load sequence.
- `abort`, in, 1: cancel the sequence and return to idle.
- `cfg_valid`, in, 1: host config word valid.
- `cfg_ready`, out, 1: controller can accept a word.
- `cfg_data`, in, `LUT_BITS`: truth-table word.
- `cfg_sdo`, out, 1: serial data to the slice chain.
- `cfg_shift_en`, out, 1: chain shift enable. The chain samples `cfg_sdo` when this is high.
- `cfg_done`, out, 1: one-cycle pulse when the load completes.
- `slice_en`, out, 1: slice array operational.
- `cfg_err`, out, 1: parity error flag (see Configuration).

## Operation
- States are IDLE, LOAD, SHIFT, DONE, RUN, plus ERROR when parity checking is compiled in.
- IDLE:
  - All outputs are low.
  - `start` moves to LOAD.
- LOAD:
  - `cfg_ready` is 1.
  - On `cfg_valid && cfg_ready`, `cfg_data` is captured into the serializer and the state moves to SHIFT.
- SHIFT:
  - `cfg_ready` is 0 and `cfg_shift_en` is 1 for exactly `LUT_BITS` cycles.
  - In shift cycle i (0-based), `cfg_sdo` equals captured bit i.
  - After the last shift cycle:
    - if the word count is below `2*NUM_SLICES-1`, increment the count and go to LOAD;
    - otherwise go to DONE.
- DONE: `cfg_done` is 1 for one cycle, then the state moves to RUN.
- RUN:
  - `slice_en` is 1.
  - `start` drops `slice_en` and moves to LOAD with the word count cleared.
- Word counter width is `$clog2(2*NUM_SLICES)`. It never wraps; reaching the terminal count forces DONE.
- Bit counter width is `$clog2(LUT_BITS)`. It is cleared on every capture.
- Total bits shifted per sequence is `2*NUM_SLICES*LUT_BITS`.
- Word order: the first word accepted ends up in the far end of the chain, which is LUT1 of the last slice.
- `abort` in any state:
  - the next state is IDLE;
  - both counters are cleared;
  - `slice_en`, `cfg_shift_en` and `cfg_ready` are 0 from the next cycle.
- Simultaneous `abort` and `start`: `abort` wins.
- `start` in LOAD, SHIFT or DONE is ignored.
- `cfg_valid` outside LOAD is ignored, and no word is consumed.
- Reset mid-sequence:
  - asynchronous return to IDLE;
  - all outputs 0 immediately;
  - a partially loaded chain is left as is and is not trusted until the next full load.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- `start` high at edge k: `cfg_ready` is 1 from cycle k+1.
- Word accepted at edge k:
  - `cfg_shift_en` is high for cycles k+1 through k+`LUT_BITS`;
  - `cfg_ready` is high again at cycle k+`LUT_BITS`+1 if more words remain.
- Final word accepted at edge k:
  - `cfg_done` is high in cycle k+`LUT_BITS`+1;
  - `slice_en` is 1 from cycle k+`LUT_BITS`+2.
- Maximum throughput is one word per `LUT_BITS`+1 cycles.

## Configuration
- Macro: `SLICE_CFG_PARITY_EN`.
- Defined:
  - an extra input `cfg_par` (in, 1) is added;
  - at capture, `^{cfg_data,cfg_par}` must be 0 (even parity);
  - on a mismatch the word is not shifted, the state goes to ERROR, and `cfg_err` is 1;
  - ERROR holds until `start`, which clears `cfg_err` and the count and goes to LOAD, or until `abort`, which goes to IDLE.
- Undefined:
  - there is no `cfg_par` port and no ERROR state;
  - `cfg_err` is tied to 0.

## Structure
- Package `slice_cfg_pkg` holds:
  - the state enum type `slice_cfg_state_t`;
  - the constant `LUTS_PER_SLICE = 2`;
  - a helper function for the word-count width.
- Sub-module `cfg_serializer`:
  - a `LUT_BITS` parallel-load, LSB-first shift register;
  - inputs are load, shift and data; outputs are sdo and a last-bit flag;
  - the FSM and counters stay in `slice_cfg_ctrl`.

## Test plan
- Full load:
  - stimulus: NUM_SLICES=4, words 0x01..0x08 sent back-to-back with `cfg_valid` held high;
  - required: 64 shift cycles; the `cfg_sdo` stream equals the words LSB first; `cfg_done` pulses once, 9 cycles after the 8th accept; `slice_en`=1 the next cycle.
- Host stall:
  - stimulus: `cfg_valid` low for 5 cycles in LOAD between words;
  - required: `cfg_ready` stays 1, no shifting occurs, and the stream is unchanged.
- Abort during SHIFT:
  - stimulus: `abort` in shift cycle 3 of word 2;
  - required: IDLE next cycle; `cfg_shift_en`=0; a subsequent `start` plus 8 words completes normally.
- Reload from RUN:
  - stimulus: `start` in RUN;
  - required: `slice_en` falls next cycle; `cfg_ready`=1; the word count restarts at 0.
- Async reset:
  - stimulus: `RST_N` low mid-LOAD, asynchronous to `CLK`;
  - required: all outputs 0 before the next edge; `start` ignored while `RST_N` is low.
- Parity (macro defined):
  - stimulus: 0x03 with `cfg_par`=1;
  - required: ERROR state; `cfg_err`=1; no shift. Then `start` clears `cfg_err` and sets `cfg_ready`=1.
